// File: rtl/fifo_ctrl_if.sv
// Producer/consumer handshake and RAM sequencing signals of the FIFO controller.
interface fifo_ctrl_if #(
  parameter int K = 4
);
  logic         clr;
  logic         wr_en;
  logic         rd_en;
  logic         ram_we;
  logic [K-1:0] ram_waddr;
  logic         ram_re;
  logic [K-1:0] ram_raddr;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [K:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output clr, wr_en, rd_en,
    input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, full, empty,
           almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, rd_en,
    output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, full, empty,
           almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag engine for a synchronous FIFO over an external
// dual-port RAM (sync write, 1-cycle registered read), standard or FWFT mode.
module fifo_ctrl #(
  parameter int K      = 4,
  parameter bit FWFT   = 1'b1,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic       clk,
  input  logic       rst,
  fifo_ctrl_if.slave bus
);
  localparam logic [K:0] DEPTH = {1'b1, {K{1'b0}}};
  localparam logic [K:0] AF    = AF_LVL[K:0];
  localparam logic [K:0] AE    = AE_LVL[K:0];

  logic [K:0] wr_ptr, rd_ptr, cnt;
  logic       dout_valid, rdv, ovf, unf;
  logic       full_c, empty_c, act, wa, pa, re;

  // clr and rst both suppress any accept so the RAM sees no strobe that cycle
  always_comb begin
    full_c  = (cnt == DEPTH);
    empty_c = FWFT ? !dout_valid : (cnt == '0);
    act     = !rst && !bus.clr;
    wa      = act && bus.wr_en && !full_c;
    pa      = act && bus.rd_en && !empty_c;
    if (FWFT) re = act && (rd_ptr != wr_ptr) && (!dout_valid || pa);
    else      re = pa;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
      rdv        <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
      rdv        <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      case ({wa, pa})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      dout_valid <= FWFT && (re || (!pa && dout_valid));
      rdv        <= !FWFT && pa;
      ovf        <= bus.wr_en && full_c;
      unf        <= bus.rd_en && empty_c;
    end
  end

  always_comb begin
    bus.ram_we       = wa;
    bus.ram_waddr    = wr_ptr[K-1:0];
    bus.ram_re       = re;
    bus.ram_raddr    = rd_ptr[K-1:0];
    bus.rd_valid     = FWFT ? !empty_c : rdv;
    bus.full         = full_c;
    bus.empty        = empty_c;
    bus.almost_full  = (cnt >= AF);
    bus.almost_empty = (cnt <= AE);
    bus.count        = cnt;
    bus.overflow     = ovf;
    bus.underflow    = unf;
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: FWFT and standard instances share one stimulus stream and
// are checked every cycle against a word-count/sequence-number reference model.
module tb_fifo_ctrl;
  localparam int K  = 4;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst, clr, wr_en, rd_en;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl_if #(.K(K)) bf ();
  fifo_ctrl_if #(.K(K)) bs ();

  assign bf.clr = clr;  assign bf.wr_en = wr_en;  assign bf.rd_en = rd_en;
  assign bs.clr = clr;  assign bs.wr_en = wr_en;  assign bs.rd_en = rd_en;

  fifo_ctrl #(.K(K), .FWFT(1'b1), .AF_LVL(AF), .AE_LVL(AE)) u_fwft (.clk(clk), .rst(rst), .bus(bf));
  fifo_ctrl #(.K(K), .FWFT(1'b0), .AF_LVL(AF), .AE_LVL(AE)) u_std  (.clk(clk), .rst(rst), .bus(bs));

  typedef struct {
    logic         we;
    logic [K-1:0] wa;
    logic         re;
    logic [K-1:0] ra;
    logic         rv, full, empty, af, ae, ov, un;
    logic [K:0]   cnt;
  } obs_t;

  obs_t of, os;
  always_comb begin
    of.we = bf.ram_we; of.wa = bf.ram_waddr; of.re = bf.ram_re; of.ra = bf.ram_raddr;
    of.rv = bf.rd_valid; of.full = bf.full; of.empty = bf.empty; of.af = bf.almost_full;
    of.ae = bf.almost_empty; of.ov = bf.overflow; of.un = bf.underflow; of.cnt = bf.count;
  end
  always_comb begin
    os.we = bs.ram_we; os.wa = bs.ram_waddr; os.re = bs.ram_re; os.ra = bs.ram_raddr;
    os.rv = bs.rd_valid; os.full = bs.full; os.empty = bs.empty; os.af = bs.almost_full;
    os.ae = bs.almost_empty; os.ov = bs.overflow; os.un = bs.underflow; os.cnt = bs.count;
  end

  // Model: totals of words written (wn), fetched from RAM (fn), popped (pn);
  // each word is tagged with its write sequence number in a bench-side RAM.
  int wn[2], fn[2], pn[2], rseq[2], dout[2];
  bit hv[2], ovq[2], unq[2], rvq[2];
  int mem[2][D];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic zero(input int m);
    wn[m] = 0; fn[m] = 0; pn[m] = 0; rseq[m] = 0;
    hv[m] = 1'b0; ovq[m] = 1'b0; unq[m] = 1'b0; rvq[m] = 1'b0;
  endtask

  task automatic model_cycle(input int m, input bit fw, input obs_t o, input string p);
    int c, nd;
    bit ef, ee, a, wa, pa, re, erv;
    if (rst) zero(m);
    c   = wn[m] - pn[m];
    ef  = (c == D);
    ee  = fw ? !hv[m] : (c == 0);
    a   = !rst && !clr;
    wa  = a && wr_en && !ef;
    pa  = a && rd_en && !ee;
    re  = fw ? (a && (wn[m] > fn[m]) && (!hv[m] || pa)) : pa;
    erv = fw ? !ee : rvq[m];
    cmp({p, ".count"}, 32'(o.cnt), c);
    cmp({p, ".full"}, 32'(o.full), 32'(ef));
    cmp({p, ".empty"}, 32'(o.empty), 32'(ee));
    cmp({p, ".almost_full"}, 32'(o.af), 32'(c >= AF));
    cmp({p, ".almost_empty"}, 32'(o.ae), 32'(c <= AE));
    cmp({p, ".rd_valid"}, 32'(o.rv), 32'(erv));
    cmp({p, ".overflow"}, 32'(o.ov), 32'(ovq[m]));
    cmp({p, ".underflow"}, 32'(o.un), 32'(unq[m]));
    cmp({p, ".ram_we"}, 32'(o.we), 32'(wa));
    cmp({p, ".ram_re"}, 32'(o.re), 32'(re));
    if (wa) cmp({p, ".ram_waddr"}, 32'(o.wa), wn[m] % D);
    if (re) cmp({p, ".ram_raddr"}, 32'(o.ra), fn[m] % D);
    if (fw && pa) cmp({p, ".head_order"}, dout[m], pn[m]);
    if (!fw && erv) begin
      cmp({p, ".read_order"}, dout[m], rseq[m]);
      rseq[m]++;
    end
    nd = dout[m];
    if (o.re === 1'b1) nd = mem[m][o.ra];
    if (o.we === 1'b1) mem[m][o.wa] = wn[m];
    dout[m] = nd;
    if (rst || clr) zero(m);
    else begin
      ovq[m] = wr_en && ef;
      unq[m] = rd_en && ee;
      rvq[m] = pa;
      wn[m] += int'(wa);
      pn[m] += int'(pa);
      fn[m] += int'(re);
      hv[m] = re ? 1'b1 : (pa ? 1'b0 : hv[m]);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      model_cycle(0, 1'b1, of, "fwft");
      model_cycle(1, 1'b0, os, "std");
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int pw;

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    zero(0); zero(1);
    started = 1'b1;
    repeat (2) nxt();
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmp("idle.f.empty", 32'(bf.empty), 1);
      cmp("idle.f.full", 32'(bf.full), 0);
      cmp("idle.f.count", 32'(bf.count), 0);
      cmp("idle.f.almost_empty", 32'(bf.almost_empty), 1);
      cmp("idle.f.ram_re", 32'(bf.ram_re), 0);
      nxt();
    end

    // single write, FWFT fetch latency, then pop
    wr_en = 1'b1;
    nxt(); wr_en = 1'b0;
    @(negedge clk);
    cmp("w1.f.ram_re", 32'(bf.ram_re), 1);
    cmp("w1.f.ram_raddr", 32'(bf.ram_raddr), 0);
    cmp("w1.f.empty", 32'(bf.empty), 1);
    cmp("w1.f.count", 32'(bf.count), 1);
    cmp("w1.s.empty", 32'(bs.empty), 0);
    nxt();
    @(negedge clk);
    cmp("w2.f.empty", 32'(bf.empty), 0);
    cmp("w2.f.count", 32'(bf.count), 1);
    nxt(); rd_en = 1'b1;
    nxt(); rd_en = 1'b0;
    @(negedge clk);
    cmp("pop.f.empty", 32'(bf.empty), 1);
    cmp("pop.f.count", 32'(bf.count), 0);
    cmp("pop.s.rd_valid", 32'(bs.rd_valid), 1);
    cmp("pop.s.count", 32'(bs.count), 0);

    // fill to full, then one rejected write
    nxt(); wr_en = 1'b1;
    repeat (11) nxt();
    @(negedge clk);
    cmp("fill11.af", 32'(bf.almost_full), 0);
    nxt();
    @(negedge clk);
    cmp("fill12.af", 32'(bf.almost_full), 1);
    cmp("fill12.count", 32'(bs.count), 12);
    repeat (4) nxt();
    @(negedge clk);
    cmp("fill16.f.full", 32'(bf.full), 1);
    cmp("fill16.s.full", 32'(bs.full), 1);
    cmp("w17.ram_we", 32'(bf.ram_we), 0);
    nxt(); wr_en = 1'b0;
    @(negedge clk);
    cmp("w17.overflow", 32'(bf.overflow), 1);
    cmp("w17.count", 32'(bf.count), 16);
    nxt();
    @(negedge clk);
    cmp("w17.overflow_end", 32'(bs.overflow), 0);

    // full with both requests: read wins
    nxt(); wr_en = 1'b1; rd_en = 1'b1;
    nxt(); wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    cmp("fullboth.f.count", 32'(bf.count), 15);
    cmp("fullboth.s.count", 32'(bs.count), 15);
    cmp("fullboth.overflow", 32'(bf.overflow), 1);
    nxt(); rd_en = 1'b1;
    repeat (15) nxt();
    rd_en = 1'b0;
    @(negedge clk);
    cmp("drain.f.empty", 32'(bf.empty), 1);
    cmp("drain.s.count", 32'(bs.count), 0);

    // empty with both requests: write wins
    nxt(); wr_en = 1'b1; rd_en = 1'b1;
    nxt(); wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    cmp("emptyboth.f.count", 32'(bf.count), 1);
    cmp("emptyboth.s.count", 32'(bs.count), 1);
    cmp("emptyboth.underflow", 32'(bf.underflow), 1);
    cmp("emptyboth.s.underflow", 32'(bs.underflow), 1);

    // clr at count 7 with a write pending
    nxt(); wr_en = 1'b1;
    repeat (6) nxt();
    wr_en = 1'b0;
    @(negedge clk);
    cmp("preclr.count", 32'(bf.count), 7);
    nxt(); clr = 1'b1; wr_en = 1'b1;
    nxt(); clr = 1'b0;
    @(negedge clk);
    cmp("clr.count", 32'(bf.count), 0);
    cmp("clr.empty", 32'(bf.empty), 1);
    cmp("clr.overflow", 32'(bf.overflow), 0);
    cmp("clr.ram_waddr", 32'(bf.ram_waddr), 0);
    cmp("clr.s.ram_waddr", 32'(bs.ram_waddr), 0);
    cmp("clr.s.count", 32'(bs.count), 0);
    nxt(); rd_en = 1'b1;

    // async reset mid-burst
    repeat (5) nxt();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    cmp("arst.count", 32'(bf.count), 0);
    cmp("arst.empty", 32'(bf.empty), 1);
    cmp("arst.full", 32'(bs.full), 0);
    cmp("arst.ram_we", 32'(bf.ram_we), 0);
    cmp("arst.ram_re", 32'(bf.ram_re), 0);
    cmp("arst.rd_valid", 32'(bs.rd_valid), 0);
    cmp("arst.almost_empty", 32'(bs.almost_empty), 1);
    wr_en = 1'b0; rd_en = 1'b0;
    nxt(); rst = 1'b0;

    // randomized traffic with shifting write/read bias
    pw = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) pw = 20 + 30 * int'($urandom_range(2));
      wr_en = ($urandom_range(99) < pw);
      rd_en = ($urandom_range(99) < (110 - pw));
      clr   = ($urandom_range(99) == 0);
      rst   = ($urandom_range(399) == 0);
      nxt();
    end
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control and flag engine for the team's synchronous FIFO. Owns the write and read pointers, the occupancy count and the full/empty/almost flags.
- Sequences an external dual-port RAM (synchronous write, registered 1-cycle read) in either standard or first-word-fall-through (FWFT) mode.
- Sits between the producer/consumer handshakes and the RAM; carries no data itself.

Parameters:
- K, 4, address width; FIFO depth = 2^K.
- FWFT, 1, 1 = head word presented on ram_dout without rd_en; 0 = standard read with 1-cycle latency.
- AF_LVL, 12, almost_full asserts when count >= AF_LVL (1..2^K).
- AE_LVL, 2, almost_empty asserts when count <= AE_LVL (0..2^K-1).

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- clr, input, 1, synchronous flush.
- wr_en, input, 1, producer write request.
- rd_en, input, 1, consumer read (standard) / pop (FWFT) request.
- ram_we, output, 1, RAM write strobe.
- ram_waddr, output, K, RAM write address.
- ram_re, output, 1, RAM read strobe.
- ram_raddr, output, K, RAM read address.
- rd_valid, output, 1, standard: ram_dout valid this cycle; FWFT: equals !empty.
- full, output, 1, count == 2^K.
- empty, output, 1, standard: count == 0; FWFT: no valid word on ram_dout.
- almost_full, output, 1, count >= AF_LVL.
- almost_empty, output, 1, count <= AE_LVL.
- count, output, K+1, occupancy: words written and not yet popped.
- overflow, output, 1, 1-cycle pulse, registered: write rejected last cycle.
- underflow, output, 1, 1-cycle pulse, registered: read rejected last cycle.

Behaviour:
- State registers:
  - wr_ptr and rd_ptr, K+1 bits each (MSB is the wrap bit).
  - count register, K+1 bits.
  - dout_valid flag, FWFT mode only.
  - overflow and underflow registers.
- Reset (rst = 1, asynchronous):
  - Pointers, count and dout_valid are 0; overflow and underflow are 0.
  - Resulting outputs: full = 0, empty = 1, almost_full = 0, almost_empty = 1, rd_valid = 0, ram_re = 0, ram_we = 0.
  - Reset asserted mid-operation discards all contents immediately.
- clr = 1 at an edge: same values as reset, applied synchronously. wr_en and rd_en in that cycle are ignored and raise no overflow/underflow.
- Write accept: wa = wr_en & !full.
  - ram_we = wa, ram_waddr = wr_ptr[K-1:0].
  - wr_ptr increments on wa, wrapping modulo 2^(K+1).
- Pop accept: pa = rd_en & !empty.
- Count update: count +1 on wa only, -1 on pa only, unchanged when both or neither.
- Flag priority: flags are evaluated from registered state at the start of the cycle.
  - When full, a simultaneous wr_en and rd_en accepts the read and rejects the write (overflow pulses).
  - When empty, a simultaneous wr_en and rd_en accepts the write and rejects the read (underflow pulses).
- overflow next = wr_en & full & !clr. underflow next = rd_en & empty & !clr.
- Standard mode (FWFT = 0):
  - ram_re = pa, ram_raddr = rd_ptr[K-1:0]; rd_ptr increments on pa.
  - rd_valid is a registered copy of pa, so data appears on ram_dout 1 cycle after rd_en.
  - A write at edge N makes empty deassert in the cycle following edge N.
- FWFT mode (FWFT = 1):
  - Fetch condition: avail = (rd_ptr != wr_ptr), i.e. an unfetched word exists in RAM.
  - ram_re = avail & (!dout_valid | pa), ram_raddr = rd_ptr[K-1:0]; rd_ptr increments on ram_re.
  - dout_valid next = ram_re ? 1 : (pa ? 0 : dout_valid).
  - empty = !dout_valid.
  - Latency: a write at edge N into an empty FIFO issues ram_re in the cycle after edge N; empty deasserts after edge N+1, i.e. 2 edges after the write.
  - Back-to-back pops with avail = 1 keep dout_valid = 1 with a new head every cycle.
  - A pop of the last word with avail = 0 drops empty to 1 at the next edge.
- Address rules:
  - full uses count, never pointer equality.
  - A RAM address is reused only after it has been fetched. FWFT count includes the word held on ram_dout, so full guarantees no overwrite of an unconsumed head.
  - Pointer wrap at 2^(K+1) is transparent; ram addresses use the low K bits.
- almost_full, almost_empty, full and empty are functions of registered state only (no combinational path from wr_en/rd_en).

Test Plan:
- Reset then idle, K = 4, FWFT = 1 -> empty = 1, full = 0, count = 0, almost_empty = 1, ram_re = 0 for 10 cycles.
- FWFT, single write at edge N -> ram_re = 1 with ram_raddr = 0 in cycle N+1; empty = 0 after edge N+1; count = 1; rd_en pop -> empty = 1, count = 0.
- Write 16 words without reads -> full = 1 and almost_full = 1 (from count = 12); 17th wr_en -> no ram_we, overflow pulses 1 cycle, count stays 16.
- Full FIFO with wr_en = rd_en = 1 for 1 cycle -> read accepted, write rejected, count = 15, overflow = 1; empty FIFO with both asserted -> write accepted, underflow = 1, count = 1.
- Standard mode, 40 interleaved write/read cycles -> read addresses wrap 15 -> 0; rd_valid 1 cycle after each accepted rd_en; read order matches write order; count never exceeds 16.
- clr asserted with count = 7 and wr_en = 1 -> count = 0, empty = 1, pointers 0, no overflow; async rst mid-burst -> all outputs at reset values before the next edge.
